// File: rtl/cpu_entry_pkg.sv
// Shared opcode constants, entry-sequence FSM states and the opcode legality helper
// for the CPU front-panel instruction entry driver.
package cpu_entry_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_NAND,
      OP_NOR, OP_XOR, OP_LD, OP_ST: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/entry_cycle_timer.sv
// Loadable down-counter with a zero flag; times the SETUP, PULSE and GAP dwell periods.
module entry_cycle_timer #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/instr_entry_driver.sv
// Drives CPU Sw/Button0 with the opcode, A, B, execute entry sequence for each accepted
// instruction. Define OPCODE_CHECK_EN to add the Err output and drop illegal opcodes.
module instr_entry_driver
  import cpu_entry_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       In_Valid,
  output logic       In_Ready,
  input  logic [3:0] In_Op,
  input  logic [3:0] In_A,
  input  logic [3:0] In_B,
  output logic [7:0] Sw,
  output logic       Button0,
  output logic       Busy,
  output logic       Done,
`ifdef OPCODE_CHECK_EN
  output logic       Err,
`endif
  output state_t     o_dbg_state
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  // Timer is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [TW-1:0] LD_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_PULSE = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] LD_GAP   = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_phase, w_phase_nxt;
  logic [7:0]  r_sw, w_sw_nxt;
  logic        r_btn, w_btn_nxt;
  logic        r_done, w_done_nxt;
  logic [3:0]  r_op, r_a, r_b;
  logic        w_capture, w_legal, w_load, w_zero;
  logic [TW-1:0] w_load_val;

  function automatic logic [7:0] payload(input logic [1:0] ph, input logic [3:0] op,
                                         input logic [3:0] a, input logic [3:0] b);
    case (ph)
      2'd0:    return {4'b0000, op};
      2'd1:    return {a, op};
      2'd2:    return {b, op};
      default: return 8'h00;
    endcase
  endfunction

  entry_cycle_timer #(.W(TW)) u_timer (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

`ifdef OPCODE_CHECK_EN
  assign w_legal = is_legal_op(In_Op);
`else
  assign w_legal = 1'b1;
`endif

  // Handshake: a transfer happens on a rising edge where In_Valid && In_Ready; one in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_sw_nxt    = r_sw;
    w_btn_nxt   = r_btn;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (In_Valid) begin
          w_capture = 1'b1;
          if (w_legal) begin
            w_state_nxt = SETUP;
            w_phase_nxt = 2'd0;
            w_sw_nxt    = {4'b0000, In_Op};
            w_btn_nxt   = 1'b0;
            w_load      = 1'b1;
            w_load_val  = LD_SETUP;
          end
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_state_nxt = PULSE;
          w_btn_nxt   = 1'b1;
          w_load      = 1'b1;
          w_load_val  = LD_PULSE;
        end
      end
      PULSE: begin
        if (w_zero) begin
          w_btn_nxt = 1'b0;
          if (r_phase != 2'd3) begin
            // Button0 falls on the same edge Sw moves to the next payload.
            w_state_nxt = SETUP;
            w_phase_nxt = r_phase + 2'd1;
            w_sw_nxt    = payload(r_phase + 2'd1, r_op, r_a, r_b);
            w_load      = 1'b1;
            w_load_val  = LD_SETUP;
          end else if (GAP_CYC > 0) begin
            w_state_nxt = GAP;
            w_sw_nxt    = 8'h00;
            w_load      = 1'b1;
            w_load_val  = LD_GAP;
          end else begin
            w_state_nxt = IDLE;
            w_sw_nxt    = 8'h00;
            w_done_nxt  = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_zero) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_phase <= 2'd0;
      r_sw    <= 8'h00;
      r_btn   <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= 4'h0;
      r_a     <= 4'h0;
      r_b     <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_sw    <= w_sw_nxt;
      r_btn   <= w_btn_nxt;
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_op <= In_Op;
        r_a  <= In_A;
        r_b  <= In_B;
      end
    end
  end

`ifdef OPCODE_CHECK_EN
  logic r_err;
  always_ff @(posedge Clock) begin
    if (Reset) r_err <= 1'b0;
    else       r_err <= w_capture && !w_legal;
  end
  assign Err = r_err;
`endif

  assign In_Ready    = (r_state == IDLE) && !Reset;
  assign Sw          = r_sw;
  assign Button0     = r_btn;
  assign Busy        = (r_state != IDLE);
  assign Done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_entry_driver.sv
// Directed bench for instr_entry_driver: default-parameter DUT plus a SETUP=3/PULSE=2/GAP=0
// DUT; per-cycle {ready,busy,done,button,sw} samples are compared against an expected queue.
module tb_instr_entry_driver;
  import cpu_entry_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       d_valid, d_ready, d_btn, d_busy, d_done;
  logic [3:0] d_op, d_a, d_b;
  logic [7:0] d_sw;
  state_t     d_state;
  logic       s_valid, s_ready, s_btn, s_busy, s_done;
  logic [3:0] s_op, s_a, s_b;
  logic [7:0] s_sw;
  state_t     s_state;
`ifdef OPCODE_CHECK_EN
  logic       d_err, s_err;
`endif

  instr_entry_driver dut (
    .Clock(clk), .Reset(rst), .In_Valid(d_valid), .In_Ready(d_ready),
    .In_Op(d_op), .In_A(d_a), .In_B(d_b), .Sw(d_sw), .Button0(d_btn),
    .Busy(d_busy), .Done(d_done),
`ifdef OPCODE_CHECK_EN
    .Err(d_err),
`endif
    .o_dbg_state(d_state)
  );

  instr_entry_driver #(.SETUP_CYC(3), .PULSE_CYC(2), .GAP_CYC(0)) dut_slow (
    .Clock(clk), .Reset(rst), .In_Valid(s_valid), .In_Ready(s_ready),
    .In_Op(s_op), .In_A(s_a), .In_B(s_b), .Sw(s_sw), .Button0(s_btn),
    .Busy(s_busy), .Done(s_done),
`ifdef OPCODE_CHECK_EN
    .Err(s_err),
`endif
    .o_dbg_state(s_state)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] samp(input bit slow);
    if (slow) return {s_ready, s_busy, s_done, s_btn, s_sw};
    return {d_ready, d_busy, d_done, d_btn, d_sw};
  endfunction

  // driver tasks
  task automatic send(input bit slow, input logic [3:0] op, input logic [3:0] a,
                      input logic [3:0] b, input bit hold);
    int waited = 0;
    @(negedge clk);
    if (slow) begin s_valid = 1'b1; s_op = op; s_a = a; s_b = b; end
    else      begin d_valid = 1'b1; d_op = op; d_a = a; d_b = b; end
    while (!(slow ? s_ready : d_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", {31'd0, (slow ? s_ready : d_ready)}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (slow) s_valid = 1'b0;
      else      d_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input bit slow);
    int k = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, k), {20'd0, samp(slow)}, {20'd0, exp_q.pop_front()});
      k++;
    end
  endtask

  // Expected per-cycle trace: 4 steps of s setup + p pulse cycles, g gap cycles, then Done.
  task automatic run_trace(input string tag, input bit slow, input logic [7:0] p0,
                           input logic [7:0] p1, input logic [7:0] p2,
                           input int s, input int p, input int g);
    int l = s + p;
    int n = 4 * l + g + 1;
    for (int k = 1; k <= n; k++) begin
      if (k <= 4 * l) begin
        int st  = (k - 1) / l;
        int off = (k - 1) % l;
        logic [7:0] pl;
        pl = (st == 0) ? p0 : (st == 1) ? p1 : (st == 2) ? p2 : 8'h00;
        exp_q.push_back({2'b01, 1'b0, (off >= s), pl});
      end else if (k <= 4 * l + g) begin
        exp_q.push_back(12'h400);
      end else begin
        exp_q.push_back(12'hA00);
      end
    end
    drain(tag, slow);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    d_valid = 1'b0; d_op = '0; d_a = '0; d_b = '0;
    s_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    check("reset_dut", {20'd0, samp(0)}, 32'h0);
    check("reset_slow", {20'd0, samp(1)}, 32'h0);
    check("reset_state", {30'd0, d_state}, {30'd0, IDLE});
    rst = 1'b0;

    // idle with In_Valid low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), {20'd0, samp(0)}, 32'h800);
    end

    // ADD(7,2), hand-computed trace: strobes on cycles 2,4,6,8, Done on 10
    send(0, OP_ADD, 4'd7, 4'd2, 0);
    exp_q = '{12'h401, 12'h501, 12'h471, 12'h571, 12'h421,
              12'h521, 12'h400, 12'h500, 12'h400, 12'hA00};
    drain("add", 0);

    // SUB(14,8) with In_Valid held; MUL(2,7) presented while busy, taken on the Done cycle
    send(0, OP_SUB, 4'd14, 4'd8, 1);
    d_op = OP_MUL; d_a = 4'd2; d_b = 4'd7;
    run_trace("sub", 0, 8'h03, 8'hE3, 8'h83, 1, 1, 1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    run_trace("mul", 0, 8'h07, 8'h27, 8'h77, 1, 1, 1);

    // Reset during phase 2 of NAND(6,15)
    send(0, OP_NAND, 4'd6, 4'd15, 0);
    repeat (5) @(negedge clk);
    check("nand_ph2", {20'd0, samp(0)}, 32'h4F8);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in", {20'd0, samp(0)}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_after", {20'd0, samp(0)}, 32'h800);
    send(0, OP_ST, 4'd5, 4'd10, 0);
    run_trace("st", 0, 8'h0F, 8'h5F, 8'hAF, 1, 1, 1);

    // slow-parameter DUT: XOR(9,13), 3 setup / 2 pulse / no gap
    send(1, OP_XOR, 4'd9, 4'd13, 0);
    run_trace("xor", 1, 8'h0B, 8'h9B, 8'hDB, 3, 2, 0);

`ifdef OPCODE_CHECK_EN
    send(0, 4'b0010, 4'd1, 4'd1, 0);
    @(negedge clk);
    check("err_pulse", {19'd0, d_err, samp(0)}, 32'h1800);
    @(negedge clk);
    check("err_clear", {19'd0, d_err, samp(0)}, 32'h0800);
    send(0, OP_LD, 4'd5, 4'd3, 0);
    run_trace("ld", 0, 8'h0E, 8'h5E, 8'h3E, 1, 1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
